// File: rtl/adc_autorange_ctrl_pkg.sv
// Shared definitions for the two-channel ADC autoranging gain scheduler:
// gain codes, channel FSM state encoding and the saturating magnitude helper.
package adc_autorange_ctrl_pkg;

    localparam logic [1:0] GAIN_X1  = 2'b00;
    localparam logic [1:0] GAIN_X10 = 2'b01;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_TRACK  = 2'd1,
        ST_MANUAL = 2'd2
    } state_t;

    // |s| for a w-bit two's complement value held sign-extended in s; the most
    // negative value saturates to the most positive so the result fits w bits.
    function automatic logic [31:0] sat_abs(input logic signed [31:0] s,
                                            input int unsigned w);
        logic signed [31:0] most_neg;
        most_neg = -(32'sd1 <<< (w - 1));
        if (s == most_neg)
            return (32'd1 << (w - 1)) - 32'd1;
        else if (s < 0)
            return $unsigned(-s);
        else
            return $unsigned(s);
    endfunction

endpackage

// File: rtl/adc_autorange_chan.sv
// One autoranging channel: SETTLE/TRACK/MANUAL FSM with overrange, dwell and
// settle counters. All outputs are registered.
module adc_autorange_chan
    import adc_autorange_ctrl_pkg::*;
#(
    parameter int              DATA_W     = 16,
    parameter logic [DATA_W-1:0] HI_THRESH = 16'd29000,
    parameter logic [DATA_W-1:0] LO_THRESH = 16'd2600,
    parameter logic [3:0]      OVR_CNT    = 4'd1,
    parameter logic [15:0]     DWELL_CNT  = 16'd1000,
    parameter logic [15:0]     SETTLE_CYC = 16'd200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              auto_en,
    input  logic [1:0]        man_gain,
    input  logic [DATA_W-1:0] adc,
    input  logic              adc_valid,
    input  logic              ovr_clr,
    output logic [1:0]        gain,
    output logic              settling,
    output logic              range_evt,
    output logic              ovr_sticky
);

    // adc_valid is a one-cycle qualifier on adc; there is no backpressure, a
    // sample not consumed in its strobe cycle is simply lost.
    state_t      state_q, state_d;
    logic [1:0]  gain_q, gain_d;
    logic        settling_q, settling_d;
    logic        evt_q, evt_d;
    logic        sticky_q, sticky_d;
    logic [15:0] settle_cnt_q, settle_cnt_d;
    logic [3:0]  ovr_cnt_q, ovr_cnt_d;
    logic [15:0] dwell_cnt_q, dwell_cnt_d;
    logic        restart;

    logic [DATA_W-1:0] mag;
    logic              is_over;
    logic              is_under;

    assign mag      = DATA_W'(sat_abs(32'(signed'(adc)), DATA_W));
    assign is_over  = (mag >= HI_THRESH);
    assign is_under = (mag < LO_THRESH);

    always_comb begin
        state_d      = state_q;
        gain_d       = gain_q;
        settling_d   = settling_q;
        evt_d        = 1'b0;
        settle_cnt_d = settle_cnt_q;
        ovr_cnt_d    = ovr_cnt_q;
        dwell_cnt_d  = dwell_cnt_q;
        restart      = 1'b0;
        sticky_d     = (adc_valid && is_over && (gain_q == GAIN_X10)) ||
                       (sticky_q && !ovr_clr);

        unique case (state_q)
            ST_SETTLE: begin
                ovr_cnt_d   = '0;
                dwell_cnt_d = '0;
                if (!auto_en && (man_gain != gain_q)) begin
                    gain_d  = man_gain;
                    restart = 1'b1;
                end else if (settle_cnt_q <= 16'd1) begin
                    settling_d = 1'b0;
                    state_d    = auto_en ? ST_TRACK : ST_MANUAL;
                end else begin
                    settle_cnt_d = settle_cnt_q - 16'd1;
                end
            end
            ST_TRACK: begin
                if (!auto_en) begin
                    ovr_cnt_d   = '0;
                    dwell_cnt_d = '0;
                    if (man_gain != gain_q) begin
                        gain_d  = man_gain;
                        restart = 1'b1;
                    end else begin
                        state_d = ST_MANUAL;
                    end
                end else if (gain_q[1]) begin
                    // Manual codes 10/11 carried into auto mode are not auto codes.
                    gain_d  = GAIN_X1;
                    restart = 1'b1;
                end else if (adc_valid) begin
                    if (gain_q[0]) begin
                        if (!is_over) begin
                            ovr_cnt_d = '0;
                        end else if (ovr_cnt_q >= OVR_CNT - 4'd1) begin
                            gain_d  = GAIN_X1;
                            evt_d   = 1'b1;
                            restart = 1'b1;
                        end else begin
                            ovr_cnt_d = ovr_cnt_q + 4'd1;
                        end
                    end else begin
                        if (!is_under) begin
                            dwell_cnt_d = '0;
                        end else if (dwell_cnt_q >= DWELL_CNT - 16'd1) begin
                            gain_d  = GAIN_X10;
                            evt_d   = 1'b1;
                            restart = 1'b1;
                        end else if (dwell_cnt_q != 16'hffff) begin
                            dwell_cnt_d = dwell_cnt_q + 16'd1;
                        end
                    end
                end
            end
            ST_MANUAL: begin
                ovr_cnt_d   = '0;
                dwell_cnt_d = '0;
                if (auto_en) begin
                    state_d = ST_TRACK;
                end else if (man_gain != gain_q) begin
                    gain_d  = man_gain;
                    restart = 1'b1;
                end
            end
            default: begin
                state_d = ST_SETTLE;
                restart = 1'b1;
            end
        endcase

        if (restart) begin
            state_d      = ST_SETTLE;
            settling_d   = 1'b1;
            settle_cnt_d = SETTLE_CYC;
            ovr_cnt_d    = '0;
            dwell_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SETTLE;
            gain_q       <= GAIN_X1;
            settling_q   <= 1'b1;
            evt_q        <= 1'b0;
            sticky_q     <= 1'b0;
            settle_cnt_q <= SETTLE_CYC;
            ovr_cnt_q    <= '0;
            dwell_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            gain_q       <= gain_d;
            settling_q   <= settling_d;
            evt_q        <= evt_d;
            sticky_q     <= sticky_d;
            settle_cnt_q <= settle_cnt_d;
            ovr_cnt_q    <= ovr_cnt_d;
            dwell_cnt_q  <= dwell_cnt_d;
        end
    end

    assign gain       = gain_q;
    assign settling   = settling_q;
    assign range_evt  = evt_q;
    assign ovr_sticky = sticky_q;

endmodule

// File: rtl/adc_autorange_ctrl.sv
// Two-channel autoranging gain scheduler for the ADC analog front end; each
// channel runs its own independent adc_autorange_chan instance.
module adc_autorange_ctrl
    import adc_autorange_ctrl_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter logic [DATA_W-1:0] HI_THRESH  = 16'd29000,
    parameter logic [DATA_W-1:0] LO_THRESH  = 16'd2600,
    parameter logic [3:0]        OVR_CNT    = 4'd1,
    parameter logic [15:0]       DWELL_CNT  = 16'd1000,
    parameter logic [15:0]       SETTLE_CYC = 16'd200
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [1:0]        auto_en_in,
    input  logic [1:0]        man_gain0_in,
    input  logic [1:0]        man_gain1_in,
    input  logic [DATA_W-1:0] adc0_in,
    input  logic              adc0_valid_in,
    input  logic [DATA_W-1:0] adc1_in,
    input  logic              adc1_valid_in,
    input  logic [1:0]        ovr_clr_in,
    output logic [1:0]        gain0_out,
    output logic [1:0]        gain1_out,
    output logic [1:0]        settling_out,
    output logic [1:0]        range_evt_out,
    output logic [1:0]        ovr_sticky_out
);

    adc_autorange_chan #(
        .DATA_W(DATA_W), .HI_THRESH(HI_THRESH), .LO_THRESH(LO_THRESH),
        .OVR_CNT(OVR_CNT), .DWELL_CNT(DWELL_CNT), .SETTLE_CYC(SETTLE_CYC)
    ) u_chan0 (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .auto_en    (auto_en_in[0]),
        .man_gain   (man_gain0_in),
        .adc        (adc0_in),
        .adc_valid  (adc0_valid_in),
        .ovr_clr    (ovr_clr_in[0]),
        .gain       (gain0_out),
        .settling   (settling_out[0]),
        .range_evt  (range_evt_out[0]),
        .ovr_sticky (ovr_sticky_out[0])
    );

    adc_autorange_chan #(
        .DATA_W(DATA_W), .HI_THRESH(HI_THRESH), .LO_THRESH(LO_THRESH),
        .OVR_CNT(OVR_CNT), .DWELL_CNT(DWELL_CNT), .SETTLE_CYC(SETTLE_CYC)
    ) u_chan1 (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .auto_en    (auto_en_in[1]),
        .man_gain   (man_gain1_in),
        .adc        (adc1_in),
        .adc_valid  (adc1_valid_in),
        .ovr_clr    (ovr_clr_in[1]),
        .gain       (gain1_out),
        .settling   (settling_out[1]),
        .range_evt  (range_evt_out[1]),
        .ovr_sticky (ovr_sticky_out[1])
    );

endmodule
